regfile_wb_arbiter: RTL and testbench

- Shares the single general-purpose register file write port among NREQ writeback sources (e.g. ALU, LSU, CSR) using round-robin arbitration.
- Drives a registered write port (rf_wen/rf_waddr/rf_wdata) straight into the 32x64 register file.
- Keeps a pending-write scoreboard so decode can stall on RAW hazards.
- Sits between the execute/memory writeback paths and the register file.

---
 rtl/regfile_wb_arbiter.sv | 137 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Round-robin share of the register file write port among NREQ
//            writeback sources, with a RAW-hazard pending scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 64,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*XLEN-1:0] req_data,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_addr,
  input  logic [AW-1:0]        rs1_addr,
  input  logic [AW-1:0]        rs2_addr,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic [31:0]          pending,
  output logic                 rf_wen,
  output logic [AW-1:0]        rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic                 err
);

  localparam int c_PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [c_PW-1:0] r_rr_ptr;
  logic            r_wen;
  logic [AW-1:0]   r_waddr;
  logic [XLEN-1:0] r_wdata;
  logic [31:0]     r_pending;
  logic            r_err;

  logic [NREQ-1:0] w_grant;
  logic            w_xfer;
  logic [c_PW-1:0] w_gnt_idx;
  int              w_scan;
  logic [AW-1:0]   w_gnt_addr;
  logic [XLEN-1:0] w_gnt_data;
  logic [31:0]     w_pending_nxt;
  logic            w_err_issue;
  logic            w_err_write;

  // Scan from the round-robin pointer, wrapping, and take the first valid source.
  always_comb begin
    w_grant   = '0;
    w_xfer    = 1'b0;
    w_gnt_idx = '0;
    w_scan    = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_scan = (int'(r_rr_ptr) + k) % NREQ;
      if (!w_xfer && req_valid[w_scan]) begin
        w_xfer    = 1'b1;
        w_gnt_idx = c_PW'(w_scan);
      end
    end
    if (hold || !rst) begin
      w_xfer = 1'b0;
    end
    if (w_xfer) begin
      w_grant[w_gnt_idx] = 1'b1;
    end
  end

  assign w_gnt_addr = req_addr[int'(w_gnt_idx)*AW +: AW];
  assign w_gnt_data = req_data[int'(w_gnt_idx)*XLEN +: XLEN];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr <= '0;
    end else if (w_xfer) begin
      r_rr_ptr <= (w_gnt_idx == c_PW'(NREQ - 1)) ? '0 : w_gnt_idx + c_PW'(1);
    end
  end

  // Writes to x0 are accepted but never reach the register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_xfer && (w_gnt_addr != '0)) begin
      r_wen   <= 1'b1;
      r_waddr <= w_gnt_addr;
      r_wdata <= w_gnt_data;
    end else begin
      r_wen   <= 1'b0;
    end
  end

  // Clear first, then set, so a new producer wins a same-edge collision.
  always_comb begin
    w_pending_nxt = r_pending;
    if (r_wen) begin
      w_pending_nxt[r_waddr] = 1'b0;
    end
    if (issue_valid && (issue_addr != '0)) begin
      w_pending_nxt[issue_addr] = 1'b1;
    end
    w_pending_nxt[0] = 1'b0;
  end

  assign w_err_issue = issue_valid && (issue_addr != '0) && r_pending[issue_addr]
                       && !(r_wen && (r_waddr == issue_addr));
  assign w_err_write = r_wen && !r_pending[r_waddr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= '0;
      r_err     <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_err_issue || w_err_write) begin
        r_err <= 1'b1;
      end
    end
  end

  assign req_ready = w_grant;
  assign rs1_busy  = rst && (rs1_addr != '0) && r_pending[rs1_addr];
  assign rs2_busy  = rst && (rs2_addr != '0) && r_pending[rs2_addr];
  assign pending   = r_pending;
  assign rf_wen    = r_wen;
  assign rf_waddr  = r_waddr;
  assign rf_wdata  = r_wdata;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// Testbench for regfile_wb_arbiter: directed scenarios checked against a
// transaction-level model every cycle, plus hand-computed literal checks.
module tb_regfile_wb_arbiter;
  localparam int NREQ = 3;
  localparam int XLEN = 64;
  localparam int AW   = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 hold;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*XLEN-1:0] req_data;
  logic                 issue_valid;
  logic [AW-1:0]        issue_addr;
  logic [AW-1:0]        rs1_addr;
  logic [AW-1:0]        rs2_addr;
  logic                 rs1_busy;
  logic                 rs2_busy;
  logic [31:0]          pending;
  logic                 rf_wen;
  logic [AW-1:0]        rf_waddr;
  logic [XLEN-1:0]      rf_wdata;
  logic                 err;

  regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .pending(pending),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int          m_rr    = 0;
  bit          m_wen   = 0;
  int          m_waddr = 0;
  logic [63:0] m_wdata = '0;
  bit          m_pend[32];
  bit          m_err   = 0;

  function automatic int model_pick();
    if (!rst || hold) return -1;
    for (int k = 0; k < NREQ; k++)
      if (req_valid[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [31:0] model_pending();
    logic [31:0] v = '0;
    for (int r = 1; r < 32; r++) v[r] = m_pend[r];
    return v;
  endfunction

  task automatic model_reset();
    m_rr = 0; m_wen = 0; m_waddr = 0; m_wdata = '0; m_err = 0;
    for (int r = 0; r < 32; r++) m_pend[r] = 0;
  endtask

  task automatic model_step();
    bit nxt[32];
    int g, a;
    g = model_pick();
    nxt = m_pend;
    if (m_wen) begin
      if (!m_pend[m_waddr]) m_err = 1;
      nxt[m_waddr] = 0;
    end
    if (issue_valid && issue_addr != 0) begin
      if (m_pend[issue_addr] && !(m_wen && m_waddr == int'(issue_addr))) m_err = 1;
      nxt[issue_addr] = 1;
    end
    m_pend = nxt;
    m_wen  = 0;
    if (g >= 0) begin
      m_rr = (g + 1) % NREQ;
      a = int'(req_addr[g*AW +: AW]);
      if (a != 0) begin
        m_wen   = 1;
        m_waddr = a;
        m_wdata = req_data[g*XLEN +: XLEN];
      end
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [NREQ-1:0] er;
      int g;
      er = '0;
      g = model_pick();
      if (g >= 0) er[g] = 1'b1;
      check("cyc_req_ready", 64'(req_ready), 64'(er));
      check("cyc_rf_wen",    64'(rf_wen),    64'(m_wen));
      check("cyc_rf_waddr",  64'(rf_waddr),  64'(m_waddr));
      check("cyc_rf_wdata",  rf_wdata,       m_wdata);
      check("cyc_pending",   64'(pending),   64'(model_pending()));
      check("cyc_rs1_busy",  64'(rs1_busy),  64'(rst && rs1_addr != 0 && m_pend[rs1_addr]));
      check("cyc_rs2_busy",  64'(rs2_busy),  64'(rst && rs2_addr != 0 && m_pend[rs2_addr]));
      check("cyc_err",       64'(err),       64'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_src(input int i, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    req_addr[i*AW +: AW]     = a;
    req_data[i*XLEN +: XLEN] = d;
  endtask

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v == (NREQ'(1) << i)) return i;
    return -1;
  endfunction

  int exp_g[6] = '{0, 1, 2, 0, 1, 2};
  int exp_a[6] = '{10, 11, 12, 13, 14, 15};
  int got_g[6];
  int got_a[6];

  initial begin
    rst = 1'b0; hold = 1'b0; req_valid = '1; req_addr = '0; req_data = '0;
    issue_valid = 1'b0; issue_addr = '0; rs1_addr = '0; rs2_addr = '0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_req_ready", 64'(req_ready), 64'h0);
    check("rst_rf_wen",    64'(rf_wen),    64'h0);
    check("rst_pending",   64'(pending),   64'h0);
    check("rst_err",       64'(err),       64'h0);
    req_valid = '0;
    rst = 1'b1;
    cmp_en = 1'b1;

    // Single write to x5 from source 1
    issue_valid = 1'b1; issue_addr = 5; rs1_addr = 5;
    step();
    issue_valid = 1'b0; req_valid = 3'b010; set_src(1, 5, 64'hDEAD_BEEF_0000_0001);
    #1;
    check("sw_ready",     64'(req_ready), 64'h2);
    check("sw_busy_pre",  64'(rs1_busy),  64'h1);
    check("sw_rs2_x0",    64'(rs2_busy),  64'h0);
    step();
    req_valid = '0;
    #1;
    check("sw_wen",       64'(rf_wen),   64'h1);
    check("sw_waddr",     64'(rf_waddr), 64'h5);
    check("sw_wdata",     rf_wdata,      64'hDEAD_BEEF_0000_0001);
    check("sw_busy_wen",  64'(rs1_busy), 64'h1);
    step();
    #1;
    check("sw_busy_post", 64'(rs1_busy), 64'h0);
    check("sw_wen_off",   64'(rf_wen),   64'h0);
    check("sw_pending",   64'(pending),  64'h0);

    // x0 write from source 2: accepted, dropped; pointer returns to 0
    req_valid = 3'b100; set_src(2, 0, 64'h55);
    #1;
    check("x0_ready", 64'(req_ready), 64'h4);
    step();
    req_valid = '0;
    #1;
    check("x0_wen",     64'(rf_wen),  64'h0);
    check("x0_pending", 64'(pending), 64'h0);

    // Round robin with all three sources busy for six cycles
    for (int k = 0; k < 6; k++) begin
      issue_valid = 1'b1; issue_addr = AW'(10 + k);
      step();
    end
    issue_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        int a;
        a = (k <= i) ? 10 + i : 13 + i;
        set_src(i, AW'(a), 64'hA000 + 64'(a));
      end
      req_valid = '1;
      #1;
      got_g[k] = onehot_idx(req_ready);
      if (k > 0) got_a[k-1] = int'(rf_waddr);
      step();
    end
    req_valid = '0;
    #1;
    got_a[5] = int'(rf_waddr);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("rr_grant%0d", k), 64'(got_g[k]), 64'(exp_g[k]));
      check($sformatf("rr_waddr%0d", k), 64'(got_a[k]), 64'(exp_a[k]));
    end
    step();
    #1;
    check("rr_pending", 64'(pending), 64'h0);
    check("rr_err",     64'(err),     64'h0);

    // Hold for three cycles
    issue_valid = 1'b1; issue_addr = 20;
    step();
    issue_valid = 1'b0; hold = 1'b1; req_valid = 3'b001; set_src(0, 20, 64'hBBBB);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("hold_ready", 64'(req_ready), 64'h0);
      check("hold_wen",   64'(rf_wen),    64'h0);
      step();
    end
    hold = 1'b0;
    #1;
    check("unhold_ready", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;
    #1;
    check("unhold_waddr", 64'(rf_waddr), 64'd20);
    check("unhold_wdata", rf_wdata,      64'hBBBB);
    step();

    // Set/clear collision on x7
    issue_valid = 1'b1; issue_addr = 7;
    step();
    issue_valid = 1'b0; req_valid = 3'b010; set_src(1, 7, 64'h7777);
    #1;
    check("col_ready", 64'(req_ready), 64'h2);
    step();
    req_valid = '0; issue_valid = 1'b1; issue_addr = 7;
    #1;
    check("col_wen",   64'(rf_wen),   64'h1);
    check("col_waddr", 64'(rf_waddr), 64'd7);
    step();
    issue_valid = 1'b0;
    #1;
    check("col_pending", 64'(pending), 64'h80);
    check("col_err",     64'(err),     64'h0);
    req_valid = 3'b100; set_src(2, 7, 64'h7778);
    step();
    req_valid = '0;
    step();
    #1;
    check("col_cleared", 64'(pending), 64'h0);

    // Double issue of x9 is a protocol error
    issue_valid = 1'b1; issue_addr = 9;
    step();
    step();
    issue_valid = 1'b0;
    #1;
    check("err_set", 64'(err), 64'h1);
    repeat (3) step();
    #1;
    check("err_sticky", 64'(err), 64'h1);

    // Asynchronous reset while a write is in the write stage
    req_valid = 3'b001; set_src(0, 9, 64'h9999);
    step();
    req_valid = '1;
    #1;
    check("ar_wen_pre", 64'(rf_wen), 64'h1);
    #1;
    rst = 1'b0;
    #1;
    check("ar_wen",     64'(rf_wen),    64'h0);
    check("ar_pending", 64'(pending),   64'h0);
    check("ar_err",     64'(err),       64'h0);
    check("ar_ready",   64'(req_ready), 64'h0);
    step();
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) set_src(i, 0, 64'h0);
    #1;
    check("ar_rr_ptr0", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;
    step();
    step();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
